// File: rtl/pixel_stream_pkg.sv
// Shared types and defaults for the pixel-buffer consumer path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package pixel_stream_pkg;

    localparam int PIXEL_W          = 24;
    localparam int DEF_LINE_WIDTH   = 1280;
    localparam int DEF_FRAME_HEIGHT = 720;
    localparam int X_W              = 11;
    localparam int Y_W              = 10;

    typedef logic [PIXEL_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // Raster tag travelling alongside the head pixel.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           sof;
        logic           eol;
    } raster_tag_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// 2-entry register FIFO for valid/ready stages; the head always lives in slot 0.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pop_rdy is ignored while empty; a push into a full buffer without a pop is dropped, so callers hold a credit.
module pixel_skid_buffer #(
    parameter int W = 24
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic [1:0]   occupancy
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop  = pop_rdy && (occ_q != 2'd0);
        do_push = push_vld && ((occ_q != 2'd2) || do_pop);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    slot0_d = push_dat;
                end else begin
                    slot1_d = push_dat;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: occupancy unchanged, FIFO order kept.
                if (occ_q == 2'd1) begin
                    slot0_d = push_dat;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_dat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

    assign head_vld  = (occ_q != 2'd0);
    assign head_dat  = slot0_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/pixel_stream_reader.sv
// Pixel-buffer consumer: issues FIFO reads, absorbs the 1-cycle read latency in a skid buffer, emits a raster-tagged stream.
// Latency: 2 cycles from fifoReadEn to outValid; 1 pixel/clk sustained.
// Backpressure: outReady low holds head and tags stable; reads stop at 2 slots held. Starvation counter under PIXEL_READER_UNDERRUN_EN.
module pixel_stream_reader
    import pixel_stream_pkg::*;
#(
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int PIXEL_WIDTH  = PIXEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   frameRestart,
    input  logic                   fifoEmpty,
    output logic                   fifoReadEn,
    input  logic [PIXEL_WIDTH-1:0] fifoData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [PIXEL_WIDTH-1:0] outPixel,
    output logic [X_W-1:0]         outX,
    output logic [Y_W-1:0]         outY,
    output logic                   outSof,
    output logic                   outEol,
    output logic [15:0]            underrunCount
);

    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_HEIGHT - 1);

    reader_state_t  state_q, state_d;
    logic           inflight_q, inflight_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [1:0]     occ;
    logic           head_vld;
    logic           pop;
    logic           restart;
    logic           x_last;
    logic           y_last;
    logic [2:0]     credit_used;
    raster_tag_t    tag;

    pixel_skid_buffer #(
        .W(PIXEL_WIDTH)
    ) u_skid (
        .core_clk (clk),
        .arst_n   (rst),
        .push_vld (inflight_q),
        .push_dat (fifoData),
        .pop_rdy  (outReady),
        .head_vld (head_vld),
        .head_dat (outPixel),
        .occupancy(occ)
    );

    assign pop     = head_vld && outReady;
    assign restart = (state_q == IDLE) && frameRestart;
    assign x_last  = (x_q == X_LAST);
    assign y_last  = (y_q == Y_LAST);

    // Slots still held after this cycle's pop; crediting the pop sustains 1 read/clk.
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifoReadEn  = (state_q == RUN) && !fifoEmpty && (credit_used < 3'd2);

    always_comb begin
        state_d    = state_q;
        inflight_d = fifoReadEn;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if ((occ == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pop) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end else if (restart) begin
            x_d = '0;
            y_d = '0;
        end
    end

    // Markers are qualified by valid so an empty buffer at (0,0) shows no SOF.
    always_comb begin
        tag.x   = x_q;
        tag.y   = y_q;
        tag.sof = head_vld && (x_q == '0) && (y_q == '0);
        tag.eol = head_vld && x_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign outValid = head_vld;
    assign outX     = tag.x;
    assign outY     = tag.y;
    assign outSof   = tag.sof;
    assign outEol   = tag.eol;

`ifdef PIXEL_READER_UNDERRUN_EN
    logic [15:0] underrun_q, underrun_d;

    // Starved mid-line: running, past column 0, nothing buffered and nothing arriving.
    always_comb begin
        underrun_d = underrun_q;
        if (restart) begin
            underrun_d = '0;
        end else if ((state_q == RUN) && (x_q != '0) && !head_vld && !inflight_q
                     && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrunCount = underrun_q;
`else
    assign underrunCount = '0;
`endif

endmodule
